serial_servo_cmd_uc: RTL and testbench
======================================

SERIAL_SERVO_CMD_UC -- requirements
Module: serial_servo_cmd_uc

Interface
REQ-001 Parameter: TIMEOUT_CICLOS, default 50000000, max clock cycles waited between bytes inside a frame.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fim_rx  input  1  one-cycle pulse from serial receiver: byte in dado_rx valid this cycle.
REQ-005 dado_rx  input  8  received ASCII byte; sampled only when fim_rx=1.
REQ-006 pronto_tx  input  1  one-cycle pulse from serial transmitter: current byte fully sent.
REQ-007 partida_tx  output  1  one-cycle start pulse to serial transmitter.
REQ-008 dado_tx  output  8  byte to transmit; stable from partida_tx until pronto_tx.
REQ-009 posicao  output  3  registered servo position index, 0..7.
REQ-010 atualiza_posicao  output  1  one-cycle pulse, posicao just changed.
REQ-011 erro  output  1  sticky flag: last complete frame was invalid.
REQ-012 db_estado  output  4  debug encoding of current state.

Function
REQ-013 Frame SHALL be 3 bytes: 'S' (0x53), digit '0'..'7' (0x30..0x37), '#' (0x23).
REQ-014 States and db_estado SHALL be: INICIAL 0x0, ESPERA_DIGITO 0x1, ESPERA_FIM 0x2, ATUALIZA 0x3, TX_OK 0x4, ESPERA_OK 0x5, TX_ERRO 0x6, ESPERA_ERRO 0x7; any illegal code -> db_estado 0xE and next state INICIAL.
REQ-015 INICIAL: fim_rx with 0x53 -> ESPERA_DIGITO; fim_rx with any other byte -> stay (byte discarded, no response).
REQ-016 ESPERA_DIGITO: fim_rx with 0x30..0x37 -> store dado_rx[2:0] in internal digit register, go ESPERA_FIM; fim_rx with any other byte -> TX_ERRO.
REQ-017 ESPERA_FIM: fim_rx with 0x23 -> ATUALIZA and posicao loads stored digit on that same edge; other byte -> TX_ERRO.
REQ-018 ATUALIZA: atualiza_posicao=1 for exactly this one cycle (posicao already new), erro cleared on exit edge; unconditional -> TX_OK.
REQ-019 TX_OK: partida_tx=1, dado_tx=0x4B ('K') for one cycle; unconditional -> ESPERA_OK.
REQ-020 ESPERA_OK: dado_tx=0x4B held; pronto_tx -> INICIAL.
REQ-021 TX_ERRO: partida_tx=1, dado_tx=0x45 ('E'), erro set on entry edge; -> ESPERA_ERRO; ESPERA_ERRO holds 0x45 until pronto_tx -> INICIAL.
REQ-022 dado_tx SHALL be 0x00 and partida_tx 0 in all states not listed above (Moore outputs, decoded from state only).
REQ-023 fim_rx SHALL be ignored in ATUALIZA, TX_*, ESPERA_OK/ERRO (bytes dropped, no state effect); pronto_tx ignored outside ESPERA_OK/ESPERA_ERRO.
REQ-024 Timeout counter SHALL clear on every state change and count each cycle in ESPERA_DIGITO/ESPERA_FIM; on reaching TIMEOUT_CICLOS-1 without fim_rx -> INICIAL, no transmission, erro and posicao unchanged.
REQ-025 fim_rx in the same cycle as timeout expiry SHALL win: byte processed per REQ-016/017.
REQ-026 Wait for pronto_tx SHALL be unbounded (no timeout in transmit states).
REQ-027 Latency: fim_rx of '#' at edge N -> atualiza_posicao high cycle N+1, partida_tx high cycle N+2.

Reset
REQ-028 reset=1 SHALL immediately force INICIAL, posicao=0, erro=0, timeout counter=0, digit register=0, partida_tx=0, atualiza_posicao=0, dado_tx=0x00, db_estado=0x0, including mid-frame or mid-transmission.
REQ-029 After reset release, first transition SHALL occur no earlier than the next rising edge.

Verification
REQ-030 Bytes 0x53,0x35,0x23 -> posicao=5, one atualiza_posicao pulse, one partida_tx with dado_tx=0x4B, return to db_estado 0x0 after pronto_tx.
REQ-031 Bytes 0x53,0x39 -> partida_tx with dado_tx=0x45, erro=1, posicao unchanged; then 0x53,0x32,0x23 -> posicao=2, erro=0.
REQ-032 Bytes 0x41,0x23 in INICIAL -> no partida_tx, db_estado stays 0x0.
REQ-033 TIMEOUT_CICLOS=16: 0x53 then silence 20 cycles -> back to 0x0, no partida_tx; repeat with fim_rx exactly at expiry cycle -> byte accepted.
REQ-034 Byte pulses on fim_rx during ESPERA_OK -> ignored; pronto_tx withheld 100 cycles -> dado_tx=0x4B held throughout.
REQ-035 reset asserted in ESPERA_FIM and again in ESPERA_OK -> all outputs at REQ-028 values asynchronously, posicao=0.

Source files
------------

// File: rtl/serial_servo_cmd_uc.sv
// Control unit for the serial servo command link: parses "S<d>#" frames,
// updates the servo position and answers 'K' (accepted) or 'E' (rejected).
module serial_servo_cmd_uc #(
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fim_rx,
  input  logic [7:0] dado_rx,
  input  logic       pronto_tx,
  output logic       partida_tx,
  output logic [7:0] dado_tx,
  output logic [2:0] posicao,
  output logic       atualiza_posicao,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL       = 4'h0;
  localparam logic [3:0] ESPERA_DIGITO = 4'h1;
  localparam logic [3:0] ESPERA_FIM    = 4'h2;
  localparam logic [3:0] ATUALIZA      = 4'h3;
  localparam logic [3:0] TX_OK         = 4'h4;
  localparam logic [3:0] ESPERA_OK     = 4'h5;
  localparam logic [3:0] TX_ERRO       = 4'h6;
  localparam logic [3:0] ESPERA_ERRO   = 4'h7;

  localparam int             CW      = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [2:0]    pos_q, pos_d;
  logic          erro_q, erro_d;

  logic is_digit, expirou, em_espera;
  assign is_digit  = (dado_rx[7:3] == 5'b00110);
  assign em_espera = (state_q == ESPERA_DIGITO) || (state_q == ESPERA_FIM);
  assign expirou   = (cnt_q == CNT_MAX);

  // fim_rx is tested before the timeout so a byte arriving on the expiry cycle wins
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    pos_d   = pos_q;
    erro_d  = erro_q;
    case (state_q)
      INICIAL:
        if (fim_rx && dado_rx == 8'h53) state_d = ESPERA_DIGITO;
      ESPERA_DIGITO:
        if (fim_rx) begin
          if (is_digit) begin
            dig_d   = dado_rx[2:0];
            state_d = ESPERA_FIM;
          end else begin
            erro_d  = 1'b1;
            state_d = TX_ERRO;
          end
        end else if (expirou) begin
          state_d = INICIAL;
        end
      ESPERA_FIM:
        if (fim_rx) begin
          if (dado_rx == 8'h23) begin
            pos_d   = dig_q;
            state_d = ATUALIZA;
          end else begin
            erro_d  = 1'b1;
            state_d = TX_ERRO;
          end
        end else if (expirou) begin
          state_d = INICIAL;
        end
      ATUALIZA: begin
        erro_d  = 1'b0;
        state_d = TX_OK;
      end
      TX_OK:       state_d = ESPERA_OK;
      ESPERA_OK:   if (pronto_tx) state_d = INICIAL;
      TX_ERRO:     state_d = ESPERA_ERRO;
      ESPERA_ERRO: if (pronto_tx) state_d = INICIAL;
      default:     state_d = INICIAL;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (em_espera)     cnt_d = cnt_q + CW'(1);
    else                    cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INICIAL;
      cnt_q   <= '0;
      dig_q   <= '0;
      pos_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pos_q   <= pos_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    partida_tx       = 1'b0;
    dado_tx          = 8'h00;
    atualiza_posicao = 1'b0;
    db_estado        = state_q;
    case (state_q)
      INICIAL, ESPERA_DIGITO, ESPERA_FIM: ;
      ATUALIZA:    atualiza_posicao = 1'b1;
      TX_OK: begin
        partida_tx = 1'b1;
        dado_tx    = 8'h4B;
      end
      ESPERA_OK:   dado_tx = 8'h4B;
      TX_ERRO: begin
        partida_tx = 1'b1;
        dado_tx    = 8'h45;
      end
      ESPERA_ERRO: dado_tx = 8'h45;
      default:     db_estado = 4'hE;
    endcase
  end

  assign posicao = pos_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_serial_servo_cmd_uc.sv
// Bench for serial_servo_cmd_uc: a frame model pushes the expected replies
// and position updates, and a monitor pops them as the DUT emits pulses.
module tb_serial_servo_cmd_uc;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fim_rx = 1'b0;
  logic [7:0] dado_rx = 8'h00;
  logic       pronto_tx = 1'b0;
  logic       partida_tx;
  logic [7:0] dado_tx;
  logic [2:0] posicao;
  logic       atualiza_posicao;
  logic       erro;
  logic [3:0] db_estado;

  serial_servo_cmd_uc #(.TIMEOUT_CICLOS(TO)) dut (
    .clock            (clock),
    .reset            (reset),
    .fim_rx           (fim_rx),
    .dado_rx          (dado_rx),
    .pronto_tx        (pronto_tx),
    .partida_tx       (partida_tx),
    .dado_tx          (dado_tx),
    .posicao          (posicao),
    .atualiza_posicao (atualiza_posicao),
    .erro             (erro),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  logic [8:0] tx_q[$];   // {erro expected during partida_tx, byte}
  logic [2:0] pos_q[$];

  int         mstate = 0;  // 0 idle, 1 want digit, 2 want '#', 3 replying
  logic [2:0] m_dig  = '0;
  logic [2:0] m_pos  = '0;
  logic       m_erro = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] mon_tx;
  logic [2:0] mon_pos;
  always @(negedge clock) begin
    if (!reset) begin
      if (partida_tx) begin
        if (tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else begin
          mon_tx = tx_q.pop_front();
          check("tx_byte", dado_tx, mon_tx[7:0]);
          check("tx_erro", erro, mon_tx[8]);
        end
      end
      if (atualiza_posicao) begin
        if (pos_q.size() == 0) check("upd_unexpected", 32'd1, 32'd0);
        else begin
          mon_pos = pos_q.pop_front();
          check("upd_posicao", posicao, mon_pos);
        end
      end
    end
  end

  task automatic model_reset();
    mstate = 0;
    m_dig  = '0;
    m_pos  = '0;
    m_erro = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    fim_rx  = 1'b1;
    dado_rx = b;
    @(posedge clock); #1;
    fim_rx  = 1'b0;
    case (mstate)
      0: if (b == 8'h53) mstate = 1;
      1: if (b >= 8'h30 && b <= 8'h37) begin
           m_dig  = b[2:0];
           mstate = 2;
         end else begin
           m_erro = 1'b1;
           tx_q.push_back({1'b1, 8'h45});
           mstate = 3;
         end
      2: if (b == 8'h23) begin
           m_pos  = m_dig;
           m_erro = 1'b0;
           pos_q.push_back(m_pos);
           tx_q.push_back({1'b0, 8'h4B});
           mstate = 3;
         end else begin
           m_erro = 1'b1;
           tx_q.push_back({1'b1, 8'h45});
           mstate = 3;
         end
      default: ;
    endcase
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!(db_estado == 4'h5 || db_estado == 4'h7) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("resp_reached", (n < 50) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic ack();
    @(posedge clock); #1;
    pronto_tx = 1'b1;
    @(posedge clock); #1;
    pronto_tx = 1'b0;
    mstate = 0;
    @(negedge clock);
    check("ack_idle", db_estado, 4'h0);
  endtask

  task automatic check_reset_outs();
    check("rst_partida", partida_tx, 1'b0);
    check("rst_atualiza", atualiza_posicao, 1'b0);
    check("rst_dado_tx", dado_tx, 8'h00);
    check("rst_db_estado", db_estado, 4'h0);
    check("rst_posicao", posicao, 3'd0);
    check("rst_erro", erro, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_reset_outs();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // Valid frame with latency checks
    send_byte(8'h53); send_byte(8'h35); send_byte(8'h23);
    @(negedge clock);
    check("lat_atualiza", atualiza_posicao, 1'b1);
    check("lat_posicao", posicao, 3'd5);
    @(negedge clock);
    check("lat_partida", partida_tx, 1'b1);
    check("lat_dado_k", dado_tx, 8'h4B);
    wait_resp();
    ack();
    check("f1_posicao", posicao, m_pos);

    // Bad digit, then a recovering frame
    send_byte(8'h53); send_byte(8'h39);
    wait_resp();
    check("bad_db", db_estado, 4'h7);
    check("bad_hold_e", dado_tx, 8'h45);
    ack();
    check("bad_erro", erro, m_erro);
    check("bad_posicao", posicao, m_pos);
    send_byte(8'h53); send_byte(8'h32); send_byte(8'h23);
    wait_resp();
    ack();
    check("rec_posicao", posicao, 3'd2);
    check("rec_erro", erro, 1'b0);

    // Garbage in idle
    send_byte(8'h41); send_byte(8'h23);
    repeat (3) @(negedge clock);
    check("idle_garbage_db", db_estado, 4'h0);

    // Silent timeout: leaves on the 16th cycle in ESPERA_DIGITO
    send_byte(8'h53);
    repeat (15) @(posedge clock);
    @(negedge clock);
    check("to_before", db_estado, 4'h1);
    @(negedge clock);
    check("to_expired", db_estado, 4'h0);
    repeat (4) @(negedge clock);
    mstate = 0;
    check("to_erro", erro, 1'b0);
    check("to_posicao", posicao, 3'd2);

    // Byte arriving on the expiry edge is accepted
    send_byte(8'h53);
    repeat (14) @(posedge clock);
    send_byte(8'h33);
    @(negedge clock);
    check("to_edge_db", db_estado, 4'h2);
    send_byte(8'h23);
    wait_resp();
    ack();
    check("to_edge_pos", posicao, 3'd3);

    // Ignored bytes and long hold in ESPERA_OK
    send_byte(8'h53); send_byte(8'h36); send_byte(8'h23);
    wait_resp();
    send_byte(8'h53); send_byte(8'h37); send_byte(8'h23);
    check("ok_ignore_db", db_estado, 4'h5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("ok_hold_k", dado_tx, 8'h4B);
    end
    ack();
    check("ok_posicao", posicao, 3'd6);

    // Reset mid-frame in ESPERA_FIM
    send_byte(8'h53); send_byte(8'h34);
    @(negedge clock);
    check("rf_db", db_estado, 4'h2);
    @(posedge clock); #2 reset = 1'b1;
    #1 check_reset_outs();
    model_reset();
    @(posedge clock); #1 reset = 1'b0;

    // Reset while waiting for pronto_tx
    send_byte(8'h53); send_byte(8'h31); send_byte(8'h23);
    wait_resp();
    check("ro_db", db_estado, 4'h5);
    check("ro_posicao", posicao, 3'd1);
    #2 reset = 1'b1;
    #1 check_reset_outs();
    model_reset();
    @(posedge clock); #1 reset = 1'b0;

    send_byte(8'h53); send_byte(8'h37); send_byte(8'h23);
    wait_resp();
    ack();
    check("post_rst_pos", posicao, 3'd7);

    repeat (3) @(negedge clock);
    check("tx_q_drained", tx_q.size(), 32'd0);
    check("pos_q_drained", pos_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
